// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and lane helpers for the load/store memory port.
package lsu_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  // Size 2'b11 falls into the default (word) arm of every helper.
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_HALF: return 4'b0011 << off;
      SIZE_BYTE: return 4'b0001 << off;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] size);
    case (size)
      SIZE_HALF: return 32'h0000_ffff;
      SIZE_BYTE: return 32'h0000_00ff;
      default:   return 32'hffff_ffff;
    endcase
  endfunction

  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_HALF: return {off[1], 1'b0};
      SIZE_BYTE: return off;
      default:   return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_HALF: return off[0];
      SIZE_BYTE: return 1'b0;
      default:   return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store enables/replication and load right-justification.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] rdata
);

  always_comb begin
    be = be_gen(size, off);
    case (size)
      SIZE_HALF: lane_wdata = {2{wdata[15:0]}};
      SIZE_BYTE: lane_wdata = {4{wdata[7:0]}};
      default:   lane_wdata = wdata;
    endcase
    rdata = (mem_rdata >> {off, 3'b000}) & lane_mask(size);
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store port with req/ack bus handshake and timeout.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses error out without a bus cycle.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]  size_q, off_q;
  logic        we_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  logic        accept, expired, trap;
  logic [1:0]  req_off, al_size, al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  assign accept  = (state_q == IDLE) && req_valid;
  assign expired = cnt_q == CNT_W'(TIMEOUT_CYC - 1);
  assign req_off = align_off(req_size, req_addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misaligned(req_size, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  // One aligner serves both directions: request fields in IDLE, latched fields in BUS.
  assign al_size = (state_q == IDLE) ? req_size : size_q;
  assign al_off  = (state_q == IDLE) ? req_off : off_q;

  lsu_lane_align u_align (
    .size       (al_size),
    .off        (al_off),
    .wdata      (req_wdata),
    .mem_rdata  (mem_rdata),
    .be         (al_be),
    .lane_wdata (al_wdata),
    .rdata      (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = trap ? RESP : BUS;
      BUS:  if (mem_ack || expired) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = state_q == IDLE;
    busy      = state_q != IDLE;
    mem_req   = state_q == BUS;
    rsp_valid = state_q == RESP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      size_q  <= SIZE_WORD;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      cnt_q <= (state_q == BUS) ? cnt_q + 1'b1 : '0;
      if (accept) begin
        size_q  <= al_size;
        off_q   <= req_off;
        we_q    <= req_we;
        addr_q  <= {req_addr[31:2], 2'b00};
        wdata_q <= al_wdata;
        be_q    <= req_we ? al_be : 4'b1111;
        rdata_q <= '0;
        err_q   <= trap;
      end else if (state_q == BUS) begin
        // Ack wins over a simultaneous timeout expiry.
        if (mem_ack) begin
          rdata_q <= we_q ? 32'h0 : al_rdata;
          err_q   <= 1'b0;
        end else if (expired) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule
